// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a requester and the ALU sequencer.
// The slave modport is the sequencer side; the master modport is the requester side.
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic [7:0]  rsp_flag;
    logic        rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_res, rsp_flag, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_res, rsp_flag, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Command front-end for an external 8-bit combinational ALU: single ops in one
// execute cycle, 8x8->16 unsigned multiply as eight shift-add passes through the ALU adder.
module alu_sequencer #(
    parameter logic [3:0] SEL_ADD = 4'b0000,
    parameter logic [4:0] OP_MUL  = 5'b10000
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   bus,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_z,
    input  logic [7:0]       alu_flag,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  sel_reg;
    logic [7:0]  a_reg;      // operand A, also the multiplicand
    logic [7:0]  b_reg;      // operand B, also the shifting multiplier / product low byte
    logic [7:0]  hi_reg;
    logic [2:0]  count_reg;
    logic [15:0] res_reg;
    logic [7:0]  flag_reg;
    logic        err_reg;

    logic        accept;
    logic [8:0]  mul_sum;
    logic [15:0] mul_prod;

    assign accept   = bus.cmd_valid && (state_reg == IDLE);
    assign mul_sum  = {alu_flag[0], alu_z};
    // Product as it stands after this pass: carry+sum shift into hi, sum LSB into lo
    assign mul_prod = {mul_sum[8:1], mul_sum[0], b_reg[7:1]};

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_res   = res_reg;
    assign bus.rsp_flag  = flag_reg;
    assign bus.rsp_err   = err_reg;
    assign busy          = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!bus.cmd_op[4])          state_next = EXEC;
                    else if (bus.cmd_op == OP_MUL) state_next = MUL;
                    else                          state_next = RESP;
                end
            end
            EXEC: state_next = RESP;
            MUL:  if (count_reg == 3'd7) state_next = RESP;
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALU is only driven while a command is actually using it
    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_sel = 4'h0;
        case (state_reg)
            EXEC: begin
                alu_a   = a_reg;
                alu_b   = b_reg;
                alu_sel = sel_reg;
            end
            MUL: begin
                alu_a   = hi_reg;
                alu_b   = b_reg[0] ? a_reg : 8'h00;
                alu_sel = SEL_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg   <= 4'h0;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            hi_reg    <= 8'h00;
            count_reg <= 3'd0;
            res_reg   <= 16'h0000;
            flag_reg  <= 8'h00;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sel_reg   <= bus.cmd_op[3:0];
                        a_reg     <= bus.cmd_a;
                        b_reg     <= bus.cmd_b;
                        hi_reg    <= 8'h00;
                        count_reg <= 3'd0;
                        res_reg   <= 16'h0000;
                        flag_reg  <= 8'h00;
                        err_reg   <= bus.cmd_op[4] && (bus.cmd_op != OP_MUL);
                    end
                end
                EXEC: begin
                    res_reg  <= {8'h00, alu_z};
                    flag_reg <= alu_flag;
                end
                MUL: begin
                    hi_reg    <= mul_prod[15:8];
                    b_reg     <= mul_prod[7:0];
                    count_reg <= count_reg + 3'd1;
                    if (count_reg == 3'd7) begin
                        res_reg  <= mul_prod;
                        flag_reg <= {6'b000000, (mul_prod == 16'h0000), (mul_prod[15:8] != 8'h00)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
